tl_ahb_bridge: RTL and testbench
================================

Name: tl_ahb_bridge

Overview:
- Bridges TileLink-UL to AHB-Lite: acts as a TL-UL responder (A in, D out) and an AHB manager (issues transfers to an AHB subordinate).
- Counterpart to the AHB-to-TL bridge; uses the same TL_*/AHB_* widths from Default_pkg.
- One outstanding transaction; all AHB and D-channel outputs are registered.

Parameters:
- TL_AW, 32, TL address width
- TL_DW, 32, TL data width (must equal AHB_DW)
- TL_SRCW, 8, source id width
- TL_SINKW, 1, sink id width
- TL_DBW, TL_DW/8, mask width
- TL_SZW, $clog2($clog2(TL_DBW)+1), size width
- AHB_AW, 32, AHB address width
- AHB_DW, 32, AHB data width
- AHB_NM, 8, HMASTER width
- MANAGER_ID, 0, value driven on HMASTER

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- tl_a_valid_i  in  1  A-channel valid
- tl_a_ready_o  out  1  A-channel ready
- tl_a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- tl_a_size_i  in  TL_SZW  log2 of byte count
- tl_a_source_i  in  TL_SRCW  source id
- tl_a_address_i  in  TL_AW  byte address
- tl_a_mask_i  in  TL_DBW  byte lanes
- tl_a_data_i  in  TL_DW  write data
- tl_d_valid_o  out  1  D-channel valid
- tl_d_ready_i  in  1  D-channel ready
- tl_d_opcode_o  out  3  0=AccessAck, 1=AccessAckData
- tl_d_size_o  out  TL_SZW  echo of a_size
- tl_d_source_o  out  TL_SRCW  echo of a_source
- tl_d_sink_o  out  TL_SINKW  always 0
- tl_d_data_o  out  TL_DW  read data (0 for Put responses)
- tl_d_error_o  out  1  error flag
- haddr_o  out  AHB_AW  address
- htrans_o  out  2  IDLE=0, NONSEQ=2 only
- hwrite_o  out  1  write
- hsize_o  out  3  {0,a_size}
- hburst_o  out  3  always SINGLE (0)
- hprot_o  out  4  always 4'b0011
- hmaster_o  out  AHB_NM  MANAGER_ID
- hwdata_o  out  AHB_DW  write data
- hwstrb_o  out  AHB_DW/8  byte strobes (= a_mask)
- hready_i  in  1  transfer done
- hresp_i  in  1  error response
- hrdata_i  in  AHB_DW  read data

Behaviour:
- Reset (async, immediate): state=IDLE; tl_a_ready_o=1; tl_d_valid_o=0; all D fields 0; htrans_o=IDLE; haddr/hwrite/hsize/hwdata/hwstrb=0; hburst_o=0; hprot_o=3; hmaster_o=MANAGER_ID.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - a_ready=1; on a_valid, capture all A fields and set a_ready=0.
  - Illegal request goes directly to RESP with d_error=1 and no AHB transfer. Illegal means any of:
    - opcode not in {0,1,4};
    - a_size > $clog2(TL_DBW);
    - address not aligned to 2^a_size;
    - Get/PutFull with mask not equal to the naturally aligned lanes for size/address;
    - PutPartial with mask bits outside the aligned lanes for size/address.
  - A legal request goes to ADDR.
- ADDR:
  - htrans=NONSEQ, haddr, hwrite=(opcode!=4), hsize, hwstrb driven.
  - Stays in ADDR while hready_i=0.
  - On hready_i=1: next cycle htrans=IDLE, hwdata=captured data; go to DATA.
- DATA:
  - Waits for hready_i=1.
  - hresp_i=1 with hready_i=0 is the first error cycle: ignore it and keep waiting.
  - On hready_i=1: latch d_error=hresp_i and d_data=(Get && !hresp_i) ? hrdata_i : 0; go to RESP.
- RESP:
  - d_valid=1; d_opcode=1 for Get, 0 for Puts, including error cases.
  - d_size, d_source echo the captured request; d_sink=0.
  - Holds all D fields stable until d_ready.
  - On d_valid&&d_ready: d_valid=0, a_ready=1, go to IDLE.
  - No new A is accepted in the same cycle as the D handshake.
- Minimum latency:
  - A handshake at cycle 0, NONSEQ visible cycles 1..n, data phase at the next cycle.
  - With zero wait states, d_valid is asserted at cycle 3 (3 cycles after the A handshake).
- Invariants:
  - htrans is never NONSEQ outside ADDR, so HTRANS=NONSEQ lasts exactly until hready_i.
  - No BUSY/SEQ transfers are issued.

Test Plan:
- Get addr 0x100, size 2, mask 0xF; zero-wait AHB returns hrdata=0xDEADBEEF → one NONSEQ read (hsize=2), d_valid 3 cycles after the A handshake, opcode=1, data=0xDEADBEEF, error=0.
- PutPartialData addr 0x202, size 1, mask 0xC, data 0xABCD0000; hready low for 2 data-phase cycles → hwstrb=0xC, hwdata held 3 cycles, d opcode=0, data=0.
- Get with two-cycle HRESP error (hresp=1/hready=0, then hresp=1/hready=1) → d_error=1, d_data=0, opcode=1.
- Misaligned Get (addr 0x101, size 2) and opcode 2 → htrans stays IDLE, d_valid at cycle 1 with error=1, opcode 1 and 0 respectively.
- Hold d_ready low 5 cycles after d_valid; a_valid held high with a new request → D fields stable, a_ready=0 until the D handshake, then the second request is accepted.
- Assert rst_i during DATA → all outputs immediately return to reset values; a following Get completes normally.

Source files
------------

// File: rtl/tl_ahb_bridge.sv
// tl_ahb_bridge
//   TileLink-UL responder to AHB-Lite manager bridge. Accepts one TL-UL A
//   request at a time. It checks the request for legality. A legal request
//   becomes one SINGLE NONSEQ AHB transfer. The result is returned on the
//   D channel. An illegal request is answered with an error straight away
//   and is never put on the bus.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   tl_a_*                TL-UL A channel (request in)
//   tl_d_*                TL-UL D channel (response out, registered)
//   h*_o                  AHB-Lite manager address/data-phase outputs (registered)
//   hready_i/hresp_i/hrdata_i  AHB-Lite subordinate response
module tl_ahb_bridge #(
  parameter int TL_AW      = 32,
  parameter int TL_DW      = 32,
  parameter int TL_SRCW    = 8,
  parameter int TL_SINKW   = 1,
  parameter int TL_DBW     = TL_DW / 8,
  parameter int TL_SZW     = $clog2($clog2(TL_DBW) + 1),
  parameter int AHB_AW     = 32,
  parameter int AHB_DW     = 32,
  parameter int AHB_NM     = 8,
  parameter int MANAGER_ID = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // TL-UL A channel
  input  logic                  tl_a_valid_i,
  output logic                  tl_a_ready_o,
  input  logic [2:0]            tl_a_opcode_i,
  input  logic [TL_SZW-1:0]     tl_a_size_i,
  input  logic [TL_SRCW-1:0]    tl_a_source_i,
  input  logic [TL_AW-1:0]      tl_a_address_i,
  input  logic [TL_DBW-1:0]     tl_a_mask_i,
  input  logic [TL_DW-1:0]      tl_a_data_i,
  // TL-UL D channel
  output logic                  tl_d_valid_o,
  input  logic                  tl_d_ready_i,
  output logic [2:0]            tl_d_opcode_o,
  output logic [TL_SZW-1:0]     tl_d_size_o,
  output logic [TL_SRCW-1:0]    tl_d_source_o,
  output logic [TL_SINKW-1:0]   tl_d_sink_o,
  output logic [TL_DW-1:0]      tl_d_data_o,
  output logic                  tl_d_error_o,
  // AHB-Lite manager
  output logic [AHB_AW-1:0]     haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic [AHB_NM-1:0]     hmaster_o,
  output logic [AHB_DW-1:0]     hwdata_o,
  output logic [AHB_DW/8-1:0]   hwstrb_o,
  input  logic                  hready_i,
  input  logic                  hresp_i,
  input  logic [AHB_DW-1:0]     hrdata_i
);

  localparam int OFFW = $clog2(TL_DBW);

  localparam logic [2:0] OP_PUTF = 3'd0;
  localparam logic [2:0] OP_PUTP = 3'd1;
  localparam logic [2:0] OP_GET  = 3'd4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_e;

  state_e               state_q, state_d;
  logic                 a_ready_q, a_ready_d;
  logic                 d_valid_q, d_valid_d;
  logic [2:0]           d_opcode_q, d_opcode_d;
  logic [TL_SZW-1:0]    d_size_q, d_size_d;
  logic [TL_SRCW-1:0]   d_source_q, d_source_d;
  logic [TL_DW-1:0]     d_data_q, d_data_d;
  logic                 d_error_q, d_error_d;
  logic [AHB_AW-1:0]    haddr_q, haddr_d;
  logic [1:0]           htrans_q, htrans_d;
  logic                 hwrite_q, hwrite_d;
  logic [2:0]           hsize_q, hsize_d;
  logic [AHB_DW-1:0]    hwdata_q, hwdata_d;
  logic [AHB_DW/8-1:0]  hwstrb_q, hwstrb_d;
  // Write data is held here until the address phase completes.
  logic [TL_DW-1:0]     wdata_q, wdata_d;

  // Request legality. Lanes are the byte lanes naturally covered by
  // size/address.
  int                   a_off;
  int                   a_bytes;
  logic [TL_DBW-1:0]    lane_mask;
  logic                 bad_op, bad_size, bad_align, bad_mask, req_illegal;

  always_comb begin
    a_off   = int'(tl_a_address_i[OFFW-1:0]);
    a_bytes = 1 << int'(tl_a_size_i);
    lane_mask = '0;
    for (int i = 0; i < TL_DBW; i++) begin
      lane_mask[i] = (i >= a_off) && (i < a_off + a_bytes);
    end
    bad_op    = !((tl_a_opcode_i == OP_PUTF) || (tl_a_opcode_i == OP_PUTP) ||
                  (tl_a_opcode_i == OP_GET));
    bad_size  = int'(tl_a_size_i) > OFFW;
    bad_align = (a_off & (a_bytes - 1)) != 0;
    // A partial put may leave lanes unused, but it must not go outside the
    // aligned window. Get and full put need the exact window.
    if (tl_a_opcode_i == OP_PUTP) bad_mask = |(tl_a_mask_i & ~lane_mask);
    else                          bad_mask = tl_a_mask_i != lane_mask;
    req_illegal = bad_op || bad_size || bad_align || bad_mask;
  end

  always_comb begin
    state_d    = state_q;
    a_ready_d  = a_ready_q;
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hwdata_d   = hwdata_q;
    hwstrb_d   = hwstrb_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tl_a_valid_i && a_ready_q) begin
          a_ready_d  = 1'b0;
          wdata_d    = tl_a_data_i;
          d_size_d   = tl_a_size_i;
          d_source_d = tl_a_source_i;
          d_opcode_d = (tl_a_opcode_i == OP_GET) ? 3'd1 : 3'd0;
          d_data_d   = '0;
          d_error_d  = 1'b0;
          if (req_illegal) begin
            // An illegal request is answered immediately and never reaches
            // the bus.
            d_error_d = 1'b1;
            d_valid_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = AHB_AW'(tl_a_address_i);
            hwrite_d = tl_a_opcode_i != OP_GET;
            hsize_d  = 3'(tl_a_size_i);
            hwstrb_d = (AHB_DW/8)'(tl_a_mask_i);
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (hready_i) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = AHB_DW'(wdata_q);
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        // The first cycle of a two-cycle error response (hresp with hready
        // low) is skipped. The error is taken when hready goes high.
        if (hready_i) begin
          d_error_d = hresp_i;
          d_data_d  = (d_opcode_q == 3'd1 && !hresp_i) ? TL_DW'(hrdata_i) : '0;
          d_valid_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tl_d_ready_i) begin
          d_valid_d = 1'b0;
          a_ready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      a_ready_q  <= 1'b1;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
      haddr_q    <= '0;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= '0;
      hwdata_q   <= '0;
      hwstrb_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_ready_q  <= a_ready_d;
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hwdata_q   <= hwdata_d;
      hwstrb_q   <= hwstrb_d;
      wdata_q    <= wdata_d;
    end
  end

  assign tl_a_ready_o  = a_ready_q;
  assign tl_d_valid_o  = d_valid_q;
  assign tl_d_opcode_o = d_opcode_q;
  assign tl_d_size_o   = d_size_q;
  assign tl_d_source_o = d_source_q;
  assign tl_d_sink_o   = '0;
  assign tl_d_data_o   = d_data_q;
  assign tl_d_error_o  = d_error_q;
  assign haddr_o       = haddr_q;
  assign htrans_o      = htrans_q;
  assign hwrite_o      = hwrite_q;
  assign hsize_o       = hsize_q;
  assign hwdata_o      = hwdata_q;
  assign hwstrb_o      = hwstrb_q;
  // Only SINGLE non-cacheable, non-bufferable privileged data accesses are issued.
  assign hburst_o      = 3'b000;
  assign hprot_o       = 4'b0011;
  assign hmaster_o     = AHB_NM'(MANAGER_ID);

endmodule

// File: tb/tb_tl_ahb_bridge.sv
// Bench for tl_ahb_bridge: directed requests. Expected D responses and AHB
// transfers are queued at issue time. A negedge monitor pops and compares
// them. The same negedge process also models the AHB subordinate.
module tb_tl_ahb_bridge;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tl_a_valid_i, tl_a_ready_o;
  logic [2:0]  tl_a_opcode_i;
  logic [1:0]  tl_a_size_i;
  logic [7:0]  tl_a_source_i;
  logic [31:0] tl_a_address_i;
  logic [3:0]  tl_a_mask_i;
  logic [31:0] tl_a_data_i;
  logic        tl_d_valid_o, tl_d_ready_i;
  logic [2:0]  tl_d_opcode_o;
  logic [1:0]  tl_d_size_o;
  logic [7:0]  tl_d_source_o;
  logic [0:0]  tl_d_sink_o;
  logic [31:0] tl_d_data_o;
  logic        tl_d_error_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o, hburst_o;
  logic [3:0]  hprot_o;
  logic [7:0]  hmaster_o;
  logic [31:0] hwdata_o;
  logic [3:0]  hwstrb_o;
  logic        hready_i, hresp_i;
  logic [31:0] hrdata_i;

  tl_ahb_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tl_a_valid_i(tl_a_valid_i), .tl_a_ready_o(tl_a_ready_o),
    .tl_a_opcode_i(tl_a_opcode_i), .tl_a_size_i(tl_a_size_i),
    .tl_a_source_i(tl_a_source_i), .tl_a_address_i(tl_a_address_i),
    .tl_a_mask_i(tl_a_mask_i), .tl_a_data_i(tl_a_data_i),
    .tl_d_valid_o(tl_d_valid_o), .tl_d_ready_i(tl_d_ready_i),
    .tl_d_opcode_o(tl_d_opcode_o), .tl_d_size_o(tl_d_size_o),
    .tl_d_source_o(tl_d_source_o), .tl_d_sink_o(tl_d_sink_o),
    .tl_d_data_o(tl_d_data_o), .tl_d_error_o(tl_d_error_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
    .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o),
    .hmaster_o(hmaster_o), .hwdata_o(hwdata_o), .hwstrb_o(hwstrb_o),
    .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } dexp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [3:0]  strb;
    logic [31:0] wd;
  } aexp_t;

  dexp_t dq[$];
  aexp_t aq[$];
  int    total = 0;
  int    bad   = 0;

  // subordinate model controls
  int          acnt = 0, dcnt = 0, sl_dwaits = 0;
  logic        sl_err = 1'b0;
  logic [31:0] sl_rdata = '0;
  logic        sdp = 1'b0, mdp = 1'b0;
  aexp_t       mcur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Subordinate first (drives hready/hresp for the coming edge), then monitor.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      sdp = 1'b0; mdp = 1'b0; hready_i = 1'b1; hresp_i = 1'b0;
    end else begin
      if (sdp) begin
        if (dcnt > 0) begin
          hready_i = 1'b0; hresp_i = sl_err && (dcnt == 1); dcnt--;
        end else begin
          hready_i = 1'b1; hresp_i = sl_err; hrdata_i = sl_rdata; sdp = 1'b0;
        end
      end else begin
        hresp_i = 1'b0; hrdata_i = 32'h5a5a_5a5a;
        if (htrans_o == 2'b10) begin
          if (acnt > 0) begin
            hready_i = 1'b0; acnt--;
          end else begin
            hready_i = 1'b1; sdp = 1'b1; dcnt = sl_dwaits;
          end
        end else hready_i = 1'b1;
      end

      // AHB monitor
      if (htrans_o == 2'b10 && hready_i) begin
        if (aq.size() == 0) begin
          total++; bad++;
          $display("FAIL ahb_unexpected: NONSEQ at addr %h with nothing pending", haddr_o);
        end else begin
          mcur = aq.pop_front();
          chk("haddr",   haddr_o, mcur.addr);
          chk("hwrite",  32'(hwrite_o), 32'(mcur.wr));
          chk("hsize",   32'(hsize_o), 32'(mcur.sz));
          chk("hwstrb",  32'(hwstrb_o), 32'(mcur.strb));
          chk("hburst",  32'(hburst_o), 32'd0);
          chk("hprot",   32'(hprot_o), 32'd3);
          chk("hmaster", 32'(hmaster_o), 32'd0);
          mdp = 1'b1;
        end
      end else if (mdp) begin
        chk("htrans_data", 32'(htrans_o), 32'd0);
        if (mcur.wr) chk("hwdata", hwdata_o, mcur.wd);
        if (hready_i) mdp = 1'b0;
      end

      // D monitor
      if (tl_d_valid_o && tl_d_ready_i) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL d_unexpected: response src %h with nothing pending", tl_d_source_o);
        end else begin
          dexp_t e;
          e = dq.pop_front();
          chk("d_opcode", 32'(tl_d_opcode_o), 32'(e.op));
          chk("d_size",   32'(tl_d_size_o), 32'(e.sz));
          chk("d_source", 32'(tl_d_source_o), 32'(e.src));
          chk("d_sink",   32'(tl_d_sink_o), 32'd0);
          chk("d_data",   tl_d_data_o, e.data);
          chk("d_error",  32'(tl_d_error_o), 32'(e.err));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wd);
    bit acc = 0;
    tl_a_opcode_i = op; tl_a_size_i = sz; tl_a_source_i = src;
    tl_a_address_i = addr; tl_a_mask_i = mask; tl_a_data_i = wd;
    tl_a_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tl_a_ready_o) begin acc = 1; break; end
      @(posedge clk_i); #1;
    end
    chk("a_accept", 32'(acc), 32'd1);
    @(posedge clk_i); #1;
    tl_a_valid_i = 1'b0;
  endtask

  // Called at posedge+1 right after the A handshake edge; returns at the
  // negedge where d_valid is seen. lat counts cycles after the handshake.
  task automatic wait_dvalid(output int lat);
    bit found = 0;
    lat = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tl_d_valid_o) begin found = 1; break; end
      @(posedge clk_i); #1;
      lat++;
    end
    chk("d_valid_seen", 32'(found), 32'd1);
  endtask

  task automatic run(input string nm, input logic [2:0] op, input logic [1:0] sz,
                     input logic [7:0] src, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] wd, input bit legal, input logic [2:0] dop,
                     input logic [31:0] ddata, input logic derr, input int elat);
    dexp_t de; aexp_t ae; int lat;
    de.op = dop; de.sz = sz; de.src = src; de.data = ddata; de.err = derr;
    dq.push_back(de);
    if (legal) begin
      ae.addr = addr; ae.wr = (op != 3'd4); ae.sz = 3'(sz); ae.strb = mask; ae.wd = wd;
      aq.push_back(ae);
    end
    issue(op, sz, src, addr, mask, wd);
    wait_dvalid(lat);
    total++;
    if (lat != elat) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", nm, lat, elat);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dexp_t de; aexp_t ae; int lat;
    logic [31:0] snap_data; logic [7:0] snap_src;
    rst_i = 1'b1; tl_a_valid_i = 1'b0; tl_a_opcode_i = '0; tl_a_size_i = '0;
    tl_a_source_i = '0; tl_a_address_i = '0; tl_a_mask_i = '0; tl_a_data_i = '0;
    tl_d_ready_i = 1'b1; hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_a_ready", 32'(tl_a_ready_o), 32'd1);
    chk("rst_d_valid", 32'(tl_d_valid_o), 32'd0);
    chk("rst_htrans",  32'(htrans_o), 32'd0);
    chk("rst_hprot",   32'(hprot_o), 32'd3);
    chk("rst_haddr",   haddr_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    sl_rdata = 32'hDEAD_BEEF;
    run("get_basic", 3'd4, 2'd2, 8'h11, 32'h100, 4'hF, 32'h0, 1, 3'd1, 32'hDEAD_BEEF, 1'b0, 3);
    sl_dwaits = 2;
    run("putp_wait", 3'd1, 2'd1, 8'h22, 32'h202, 4'hC, 32'hABCD_0000, 1, 3'd0, 32'h0, 1'b0, 5);
    sl_dwaits = 1; sl_err = 1'b1;
    run("get_err", 3'd4, 2'd2, 8'h33, 32'h104, 4'hF, 32'h0, 1, 3'd1, 32'h0, 1'b1, 4);
    sl_dwaits = 0; sl_err = 1'b0;
    run("misalign", 3'd4, 2'd2, 8'h44, 32'h101, 4'hF, 32'h0, 0, 3'd1, 32'h0, 1'b1, 1);
    run("bad_op",   3'd2, 2'd2, 8'h55, 32'h100, 4'hF, 32'h0, 0, 3'd0, 32'h0, 1'b1, 1);
    run("putf_mask", 3'd0, 2'd2, 8'h66, 32'h100, 4'h3, 32'h0, 0, 3'd0, 32'h0, 1'b1, 1);
    run("size3",    3'd4, 2'd3, 8'h67, 32'h100, 4'hF, 32'h0, 0, 3'd1, 32'h0, 1'b1, 1);
    run("putp_out", 3'd1, 2'd1, 8'h68, 32'h202, 4'h3, 32'h0, 0, 3'd0, 32'h0, 1'b1, 1);
    acnt = 2;
    run("putf_await", 3'd0, 2'd2, 8'h77, 32'h300, 4'hF, 32'h1234_5678, 1, 3'd0, 32'h0, 1'b0, 5);
    sl_rdata = 32'hCAFE_F00D;
    run("get_byte", 3'd4, 2'd0, 8'h88, 32'h103, 4'h8, 32'h0, 1, 3'd1, 32'hCAFE_F00D, 1'b0, 3);
    run("putp_zero", 3'd1, 2'd2, 8'h89, 32'h208, 4'h0, 32'h0BAD_0000, 1, 3'd0, 32'h0, 1'b0, 3);

    // D backpressure with a second request waiting on A
    sl_rdata = 32'h1111_2222; tl_d_ready_i = 1'b0;
    de.op = 3'd1; de.sz = 2'd2; de.src = 8'hA1; de.data = 32'h1111_2222; de.err = 1'b0;
    dq.push_back(de);
    ae.addr = 32'h400; ae.wr = 1'b0; ae.sz = 3'd2; ae.strb = 4'hF; ae.wd = '0;
    aq.push_back(ae);
    issue(3'd4, 2'd2, 8'hA1, 32'h400, 4'hF, 32'h0);
    tl_a_opcode_i = 3'd4; tl_a_size_i = 2'd2; tl_a_source_i = 8'hA2;
    tl_a_address_i = 32'h404; tl_a_mask_i = 4'hF; tl_a_valid_i = 1'b1;
    wait_dvalid(lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL bp_latency: got %0d want 3", lat); end
    snap_data = tl_d_data_o; snap_src = tl_d_source_o;
    chk("bp_data_first", snap_data, 32'h1111_2222);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("bp_d_valid_held", 32'(tl_d_valid_o), 32'd1);
      chk("bp_d_data_held",  tl_d_data_o, snap_data);
      chk("bp_d_src_held",   32'(tl_d_source_o), 32'(snap_src));
      chk("bp_a_ready_low",  32'(tl_a_ready_o), 32'd0);
    end
    @(posedge clk_i); #1;
    sl_rdata = 32'h3333_4444;
    de.src = 8'hA2; de.data = 32'h3333_4444;
    dq.push_back(de);
    ae.addr = 32'h404;
    aq.push_back(ae);
    tl_d_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_no_accept_in_handshake", 32'(tl_a_ready_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("bp_a_ready_after", 32'(tl_a_ready_o), 32'd1);
    @(posedge clk_i); #1;
    tl_a_valid_i = 1'b0;
    wait_dvalid(lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL bp2_latency: got %0d want 3", lat); end
    @(posedge clk_i); #1;

    // Reset in the middle of a data phase
    sl_dwaits = 3;
    ae.addr = 32'h500; ae.wr = 1'b1; ae.sz = 3'd2; ae.strb = 4'hF; ae.wd = 32'h5555_AAAA;
    aq.push_back(ae);
    issue(3'd0, 2'd2, 8'hB0, 32'h500, 4'hF, 32'h5555_AAAA);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_a_ready", 32'(tl_a_ready_o), 32'd1);
    chk("mid_rst_d_valid", 32'(tl_d_valid_o), 32'd0);
    chk("mid_rst_htrans",  32'(htrans_o), 32'd0);
    chk("mid_rst_haddr",   haddr_o, 32'd0);
    chk("mid_rst_hwrite",  32'(hwrite_o), 32'd0);
    chk("mid_rst_hwdata",  hwdata_o, 32'd0);
    chk("mid_rst_hwstrb",  32'(hwstrb_o), 32'd0);
    chk("mid_rst_d_src",   32'(tl_d_source_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; sl_dwaits = 0; sl_rdata = 32'h600D_F00D;
    run("get_after_rst", 3'd4, 2'd2, 8'hB1, 32'h504, 4'hF, 32'h0, 1, 3'd1, 32'h600D_F00D, 1'b0, 3);

    repeat (3) @(posedge clk_i);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("aq_drained", 32'(aq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
